// File: rtl/nrisc_pkg.sv
// Shared definitions for the nRisc run controller: state encoding, halt opcode
// and default bus widths.
package nrisc_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 8;

    localparam logic [7:0] HALT_OPCODE = 8'h00;

    // Plain vector encoding keeps the state register easy to probe from legacy benches.
    typedef logic [2:0] run_state_t;

    localparam run_state_t ST_IDLE = 3'd0;
    localparam run_state_t ST_LOAD = 3'd1;
    localparam run_state_t ST_ARM  = 3'd2;
    localparam run_state_t ST_RUN  = 3'd3;
    localparam run_state_t ST_HALT = 3'd4;

    function automatic logic can_start(input run_state_t state);
        return (state == ST_IDLE) || (state == ST_HALT);
    endfunction

endpackage

// File: rtl/cycle_watchdog.sv
// Saturating RUN-cycle counter; with RUN_CTRL_TIMEOUT_EN defined it also flags
// the cycle in which the count reaches MAX_CYCLES.
module cycle_watchdog #(
    parameter int               CYC_W      = 16,
    parameter logic [CYC_W-1:0] MAX_CYCLES = 16'd4096
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    output logic [CYC_W-1:0] count
`ifdef RUN_CTRL_TIMEOUT_EN
    ,
    output logic             limit_hit
`endif
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != '1)) begin
            count <= count + CYC_W'(1);
        end
    end

`ifdef RUN_CTRL_TIMEOUT_EN
    // Fires during the cycle that brings the count to MAX_CYCLES, so the halt
    // lands exactly when the counter shows the limit.
    assign limit_hit = enable && (count >= (MAX_CYCLES - CYC_W'(1)));
`else
    logic unused_limit;
    assign unused_limit = ^MAX_CYCLES;
`endif

endmodule

// File: rtl/nrisc_run_controller.sv
// Run lifecycle sequencer for the nRisc core: program load, reset settle, run and
// halt detection. Optional watchdog halt enabled by defining RUN_CTRL_TIMEOUT_EN.
module nrisc_run_controller
    import nrisc_pkg::*;
#(
    parameter int               ADDR_W     = ADDR_W_DEF,
    parameter int               DATA_W     = DATA_W_DEF,
    parameter int               CYC_W      = 16,
    parameter logic [CYC_W-1:0] MAX_CYCLES = 16'd4096
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Start,
    input  logic              Abort,
    input  logic              LoadValid,
    output logic              LoadReady,
    input  logic [DATA_W-1:0] LoadData,
    input  logic              LoadLast,
    output logic              ImemWrite,
    output logic [ADDR_W-1:0] ImemAddr,
    output logic [DATA_W-1:0] ImemData,
    output logic              CoreReset,
    input  logic [ADDR_W-1:0] CorePC,
    input  logic [DATA_W-1:0] CoreInstr,
    output logic              Busy,
    output logic              Halted,
    output logic              Timeout,
    output logic [ADDR_W-1:0] HaltPC,
    output logic [ADDR_W:0]   ProgLen,
    output logic [CYC_W-1:0]  CycleCount
);

    run_state_t        state;
    logic [ADDR_W-1:0] load_addr;
    logic [ADDR_W:0]   prog_len;
    logic              transfer;
    logic              last_byte;
    logic              start_req;
    logic              halt_seen;
    logic              limit_hit;
    logic              halt_now;

    assign transfer  = LoadValid && LoadReady;
    assign last_byte = LoadLast || (load_addr == '1);
    assign start_req = Start && !Abort && can_start(state);
    assign halt_seen = (state == ST_RUN) && (CoreInstr == DATA_W'(HALT_OPCODE));
    assign halt_now  = (state == ST_RUN) && !Abort && (halt_seen || limit_hit);

    assign LoadReady = (state == ST_LOAD);
    assign CoreReset = (state != ST_RUN);
    assign Busy      = (state == ST_LOAD) || (state == ST_ARM) || (state == ST_RUN);
    assign Halted    = (state == ST_HALT);
    assign ProgLen   = prog_len;

`ifdef RUN_CTRL_TIMEOUT_EN
    cycle_watchdog #(
        .CYC_W      (CYC_W),
        .MAX_CYCLES (MAX_CYCLES)
    ) u_watchdog (
        .clk       (Clock),
        .rst       (Reset),
        .clear     (start_req),
        .enable    (state == ST_RUN),
        .count     (CycleCount),
        .limit_hit (limit_hit)
    );
`else
    cycle_watchdog #(
        .CYC_W      (CYC_W),
        .MAX_CYCLES (MAX_CYCLES)
    ) u_watchdog (
        .clk    (Clock),
        .rst    (Reset),
        .clear  (start_req),
        .enable (state == ST_RUN),
        .count  (CycleCount)
    );

    assign limit_hit = 1'b0;
`endif

    // Abort outranks everything, including a simultaneous Start in IDLE/HALT.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state <= ST_IDLE;
        end else if (Abort) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE, ST_HALT: if (Start) state <= ST_LOAD;
                ST_LOAD:          if (transfer && last_byte) state <= ST_ARM;
                ST_ARM:           state <= ST_RUN;
                ST_RUN:           if (halt_now) state <= ST_HALT;
                default:          state <= ST_IDLE;
            endcase
        end
    end

    // A byte accepted on the Abort edge is still written; the address stops at the
    // top entry instead of wrapping so entry 0 is never overwritten.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            ImemWrite <= 1'b0;
            ImemAddr  <= '0;
            ImemData  <= '0;
            load_addr <= '0;
            prog_len  <= '0;
        end else begin
            ImemWrite <= transfer;
            if (transfer) begin
                ImemAddr <= load_addr;
                ImemData <= LoadData;
                prog_len <= prog_len + (ADDR_W+1)'(1);
                if (!last_byte) begin
                    load_addr <= load_addr + ADDR_W'(1);
                end
            end
            if (start_req) begin
                load_addr <= '0;
                prog_len  <= '0;
            end
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            HaltPC <= '0;
        end else if (start_req) begin
            HaltPC <= '0;
        end else if (halt_now) begin
            HaltPC <= CorePC;
        end
    end

`ifdef RUN_CTRL_TIMEOUT_EN
    // The opcode wins a tie with the watchdog, so Timeout only marks a pure limit halt.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            Timeout <= 1'b0;
        end else if (start_req) begin
            Timeout <= 1'b0;
        end else if (halt_now) begin
            Timeout <= !halt_seen;
        end
    end
`else
    assign Timeout = 1'b0;
`endif

endmodule

// File: tb/tb_nrisc_run_controller.sv
// Directed self-checking bench for nrisc_run_controller; the watchdog scenario
// follows RUN_CTRL_TIMEOUT_EN like the design does.
module tb_nrisc_run_controller;

    logic        Clock;
    logic        Reset;
    logic        Start;
    logic        Abort;
    logic        LoadValid;
    logic        LoadReady;
    logic [7:0]  LoadData;
    logic        LoadLast;
    logic        ImemWrite;
    logic [7:0]  ImemAddr;
    logic [7:0]  ImemData;
    logic        CoreReset;
    logic [7:0]  CorePC;
    logic [7:0]  CoreInstr;
    logic        Busy;
    logic        Halted;
    logic        Timeout;
    logic [7:0]  HaltPC;
    logic [8:0]  ProgLen;
    logic [15:0] CycleCount;

    int total = 0;
    int bad   = 0;

    logic watch_zero = 1'b0;
    int   zero_writes = 0;

    nrisc_run_controller #(
        .ADDR_W     (8),
        .DATA_W     (8),
        .CYC_W      (16),
        .MAX_CYCLES (16'd10)
    ) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .Start      (Start),
        .Abort      (Abort),
        .LoadValid  (LoadValid),
        .LoadReady  (LoadReady),
        .LoadData   (LoadData),
        .LoadLast   (LoadLast),
        .ImemWrite  (ImemWrite),
        .ImemAddr   (ImemAddr),
        .ImemData   (ImemData),
        .CoreReset  (CoreReset),
        .CorePC     (CorePC),
        .CoreInstr  (CoreInstr),
        .Busy       (Busy),
        .Halted     (Halted),
        .Timeout    (Timeout),
        .HaltPC     (HaltPC),
        .ProgLen    (ProgLen),
        .CycleCount (CycleCount)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    always @(negedge Clock) begin
        if (watch_zero && ImemWrite && (ImemAddr == 8'h00)) zero_writes++;
    end

    task automatic test_reset;
        Reset = 1'b1;
        repeat (2) @(negedge Clock);
        total++; if (LoadReady !== 1'b0) begin bad++; $display("[TB] FAIL reset_ready got=%0b want=0", LoadReady); end
        total++; if (CoreReset !== 1'b1) begin bad++; $display("[TB] FAIL reset_core got=%0b want=1", CoreReset); end
        total++; if ({Busy, Halted, Timeout, ImemWrite} !== 4'b0000) begin bad++; $display("[TB] FAIL reset_flags got=%b want=0000", {Busy, Halted, Timeout, ImemWrite}); end
        total++; if ({HaltPC, ProgLen, CycleCount, ImemAddr, ImemData} !== '0) begin bad++; $display("[TB] FAIL reset_regs got=%h want=0", {HaltPC, ProgLen, CycleCount, ImemAddr, ImemData}); end

        Reset = 1'b0;
        Start = 1'b1;
        @(negedge Clock);
        Start = 1'b0;
        total++; if (LoadReady !== 1'b1) begin bad++; $display("[TB] FAIL load_ready got=%0b want=1", LoadReady); end
        LoadValid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            LoadData = 8'hA0 + 8'(i);
            @(negedge Clock);
        end
        LoadValid = 1'b0;
        total++; if (ProgLen !== 9'd3) begin bad++; $display("[TB] FAIL midload_len got=%0d want=3", ProgLen); end
        total++; if ({ImemWrite, ImemAddr, ImemData} !== {1'b1, 8'h02, 8'hA2}) begin bad++; $display("[TB] FAIL midload_write got=%h want=%h", {ImemWrite, ImemAddr, ImemData}, {1'b1, 8'h02, 8'hA2}); end

        #2 Reset = 1'b1;
        #1;
        total++; if ({LoadReady, CoreReset, Busy, ImemWrite} !== 4'b0100) begin bad++; $display("[TB] FAIL async_reset_flags got=%b want=0100", {LoadReady, CoreReset, Busy, ImemWrite}); end
        total++; if ({ProgLen, ImemAddr, ImemData} !== '0) begin bad++; $display("[TB] FAIL async_reset_regs got=%h want=0", {ProgLen, ImemAddr, ImemData}); end
        @(negedge Clock);
        Reset = 1'b0;
    endtask

    task automatic test_load_run_halt;
        logic [7:0] prog [4];
        prog[0] = 8'h41; prog[1] = 8'h52; prog[2] = 8'h13; prog[3] = 8'h00;
        CoreInstr = 8'h41;
        CorePC    = 8'h00;
        Start = 1'b1;
        @(negedge Clock);
        Start = 1'b0;
        LoadValid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            LoadData = prog[i];
            LoadLast = (i == 3);
            @(negedge Clock);
            total++; if ({ImemWrite, ImemAddr, ImemData} !== {1'b1, 8'(i), prog[i]}) begin bad++; $display("[TB] FAIL load4_write%0d got=%h want=%h", i, {ImemWrite, ImemAddr, ImemData}, {1'b1, 8'(i), prog[i]}); end
            total++; if (LoadReady !== (i != 3)) begin bad++; $display("[TB] FAIL load4_ready%0d got=%0b want=%0b", i, LoadReady, (i != 3)); end
        end
        LoadValid = 1'b0;
        LoadLast  = 1'b0;
        total++; if ({ProgLen, Busy, CoreReset} !== {9'd4, 1'b1, 1'b1}) begin bad++; $display("[TB] FAIL arm_state got=%h want=%h", {ProgLen, Busy, CoreReset}, {9'd4, 1'b1, 1'b1}); end
        @(negedge Clock);
        total++; if ({CoreReset, ImemWrite, Busy} !== 3'b001) begin bad++; $display("[TB] FAIL run_entry got=%b want=001", {CoreReset, ImemWrite, Busy}); end
        for (int j = 1; j <= 7; j++) begin
            CorePC = 8'(j);
            @(negedge Clock);
        end
        total++; if ({Halted, CycleCount} !== {1'b0, 16'd7}) begin bad++; $display("[TB] FAIL run_count7 got=%h want=%h", {Halted, CycleCount}, {1'b0, 16'd7}); end
        CoreInstr = 8'h00;
        CorePC    = 8'h03;
        @(negedge Clock);
        CoreInstr = 8'h41;
        total++; if ({Halted, CoreReset, Busy, Timeout} !== 4'b1100) begin bad++; $display("[TB] FAIL halt_flags got=%b want=1100", {Halted, CoreReset, Busy, Timeout}); end
        total++; if (HaltPC !== 8'h03) begin bad++; $display("[TB] FAIL halt_pc got=%h want=03", HaltPC); end
        total++; if (CycleCount !== 16'd8) begin bad++; $display("[TB] FAIL halt_count got=%0d want=8", CycleCount); end
    endtask

    task automatic test_halt_restart;
        Abort = 1'b1;
        Start = 1'b1;
        @(negedge Clock);
        Abort = 1'b0;
        Start = 1'b0;
        total++; if ({Halted, Busy, LoadReady} !== 3'b000) begin bad++; $display("[TB] FAIL abort_beats_start got=%b want=000", {Halted, Busy, LoadReady}); end

        Start = 1'b1;
        @(negedge Clock);
        Start = 1'b0;
        LoadValid = 1'b1;
        LoadLast  = 1'b1;
        LoadData  = 8'h00;
        CoreInstr = 8'h00;
        CorePC    = 8'h07;
        @(negedge Clock);
        LoadValid = 1'b0;
        LoadLast  = 1'b0;
        total++; if (ProgLen !== 9'd1) begin bad++; $display("[TB] FAIL one_byte_len got=%0d want=1", ProgLen); end
        @(negedge Clock);
        total++; if (CoreReset !== 1'b0) begin bad++; $display("[TB] FAIL first_run_core got=%0b want=0", CoreReset); end
        @(negedge Clock);
        CoreInstr = 8'h41;
        total++; if ({Halted, CycleCount, HaltPC} !== {1'b1, 16'd1, 8'h07}) begin bad++; $display("[TB] FAIL first_cycle_halt got=%h want=%h", {Halted, CycleCount, HaltPC}, {1'b1, 16'd1, 8'h07}); end

        Start = 1'b1;
        @(negedge Clock);
        Start = 1'b0;
        total++; if ({LoadReady, Halted, Busy} !== 3'b101) begin bad++; $display("[TB] FAIL restart_state got=%b want=101", {LoadReady, Halted, Busy}); end
        total++; if ({CycleCount, HaltPC, ProgLen} !== '0) begin bad++; $display("[TB] FAIL restart_clear got=%h want=0", {CycleCount, HaltPC, ProgLen}); end
        Abort = 1'b1;
        @(negedge Clock);
        Abort = 1'b0;
        total++; if ({Busy, CoreReset} !== 2'b01) begin bad++; $display("[TB] FAIL abort_load got=%b want=01", {Busy, CoreReset}); end
    endtask

    task automatic test_full_load;
        int addr_errs = 0;
        Start = 1'b1;
        @(negedge Clock);
        Start = 1'b0;
        zero_writes = 0;
        watch_zero  = 1'b1;
        LoadValid   = 1'b1;
        for (int i = 0; i < 256; i++) begin
            LoadData = 8'(i) ^ 8'h5A;
            @(negedge Clock);
            if ({ImemWrite, ImemAddr, ImemData} !== {1'b1, 8'(i), 8'(i) ^ 8'h5A}) addr_errs++;
        end
        total++; if (addr_errs !== 0) begin bad++; $display("[TB] FAIL full_load_writes got=%0d errors want=0", addr_errs); end
        total++; if ({LoadReady, ProgLen} !== {1'b0, 9'd256}) begin bad++; $display("[TB] FAIL full_load_end got=%h want=%h", {LoadReady, ProgLen}, {1'b0, 9'd256}); end
        repeat (3) @(negedge Clock);
        total++; if (ImemWrite !== 1'b0) begin bad++; $display("[TB] FAIL full_load_extra_write got=%0b want=0", ImemWrite); end
        total++; if (zero_writes !== 1) begin bad++; $display("[TB] FAIL full_load_addr0 got=%0d want=1", zero_writes); end
        watch_zero = 1'b0;
        LoadValid  = 1'b0;
        Abort = 1'b1;
        @(negedge Clock);
        Abort = 1'b0;
        total++; if ({Busy, CoreReset} !== 2'b01) begin bad++; $display("[TB] FAIL abort_run got=%b want=01", {Busy, CoreReset}); end
    endtask

    task automatic test_timeout;
        Start = 1'b1;
        @(negedge Clock);
        Start = 1'b0;
        LoadValid = 1'b1;
        LoadLast  = 1'b1;
        LoadData  = 8'h41;
        CoreInstr = 8'h41;
        CorePC    = 8'h09;
        @(negedge Clock);
        LoadValid = 1'b0;
        LoadLast  = 1'b0;
        @(negedge Clock);
        repeat (10) @(negedge Clock);
`ifdef RUN_CTRL_TIMEOUT_EN
        total++; if ({Halted, Timeout, CoreReset} !== 3'b111) begin bad++; $display("[TB] FAIL timeout_flags got=%b want=111", {Halted, Timeout, CoreReset}); end
        total++; if ({CycleCount, HaltPC} !== {16'd10, 8'h09}) begin bad++; $display("[TB] FAIL timeout_regs got=%h want=%h", {CycleCount, HaltPC}, {16'd10, 8'h09}); end
`else
        total++; if ({Busy, Halted, Timeout, CycleCount} !== {3'b100, 16'd10}) begin bad++; $display("[TB] FAIL no_watchdog_10 got=%h want=%h", {Busy, Halted, Timeout, CycleCount}, {3'b100, 16'd10}); end
        repeat (5) @(negedge Clock);
        total++; if ({Busy, Halted, CycleCount} !== {2'b10, 16'd15}) begin bad++; $display("[TB] FAIL no_watchdog_15 got=%h want=%h", {Busy, Halted, CycleCount}, {2'b10, 16'd15}); end
`endif
        Abort = 1'b1;
        @(negedge Clock);
        Abort = 1'b0;
    endtask

    initial begin
        Reset     = 1'b1;
        Start     = 1'b0;
        Abort     = 1'b0;
        LoadValid = 1'b0;
        LoadData  = 8'h00;
        LoadLast  = 1'b0;
        CorePC    = 8'h00;
        CoreInstr = 8'h41;
        test_reset();
        test_load_run_halt();
        test_halt_restart();
        test_full_load();
        test_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/nrisc_run_controller.md
# nrisc_run_controller

Sequencer that owns the run lifecycle of the nRisc 8-bit core. It streams a program into instruction memory over a valid/ready byte interface, then holds the core in reset for one settle cycle and releases it. It watches fetched instructions for the halt opcode (8'h00) and reports halt PC and executed cycle count. It sits between the host/bench and the core plus its instruction memory, replacing ad-hoc bench-side loading and halt detection.

## Interface
- ADDR_W, 8, instruction memory address width (256 entries)
- DATA_W, 8, instruction width
- CYC_W, 16, cycle counter width
- MAX_CYCLES, 16'd4096, watchdog limit (used only with RUN_CTRL_TIMEOUT_EN)

- Clock  in  1  single system clock, rising edge
- Reset  in  1  asynchronous, active-high
- Start  in  1  level sampled each cycle; begins load from IDLE or HALT
- Abort  in  1  returns to IDLE from any state
- LoadValid  in  1  byte available
- LoadReady  out  1  controller accepts byte
- LoadData  in  DATA_W  program byte
- LoadLast  in  1  marks final byte
- ImemWrite  out  1  instruction memory write strobe
- ImemAddr  out  ADDR_W  write address
- ImemData  out  DATA_W  write data
- CoreReset  out  1  active-high reset to core and PC
- CorePC  in  ADDR_W  core program counter
- CoreInstr  in  DATA_W  instruction currently fetched
- Busy  out  1  state is LOAD, ARM or RUN
- Halted  out  1  state is HALT
- Timeout  out  1  halt caused by watchdog
- HaltPC  out  ADDR_W  CorePC captured at halt
- ProgLen  out  ADDR_W+1  bytes loaded (1..256)
- CycleCount  out  CYC_W  RUN cycles executed

## Operation
- States: IDLE, LOAD, ARM, RUN, HALT.
- Reset values: state IDLE, LoadReady 0, ImemWrite 0, ImemAddr 0, ImemData 0, CoreReset 1, Busy 0, Halted 0, Timeout 0, HaltPC 0, ProgLen 0, CycleCount 0.
- IDLE/HALT: Start=1 -> LOAD; clears address counter, ProgLen, CycleCount, Timeout, HaltPC.
- LOAD: LoadReady=1. Transfer = LoadValid&LoadReady. Each transfer writes byte at current address, increments address and ProgLen. Transfer with LoadLast=1, or the 256th transfer (address 8'hFF), -> ARM; LoadReady drops same edge; address never wraps.
- ARM: one cycle, CoreReset still 1, last write lands -> RUN.
- RUN: CoreReset=0; CycleCount +1 per cycle, saturating at all-ones. CoreInstr==8'h00 in any RUN cycle (including the first) -> HALT, HaltPC<=CorePC, CoreReset<=1.
- CoreReset=1 in every state except RUN.
- Abort=1 -> IDLE from any state; ImemWrite for an already-accepted byte still issues. Abort beats Start when both are high.
- Start ignored in LOAD, ARM, RUN.

## Timing
- Start high in IDLE at edge N -> LOAD, LoadReady=1 from N+1.
- Transfer at edge N -> ImemWrite=1, ImemAddr/ImemData valid during cycle N+1 only (registered, one-cycle strobe). Back-to-back transfers give back-to-back strobes.
- Last transfer at edge N -> ARM during N+1 (strobe of last byte visible), RUN from N+2, CoreReset low from N+2.
- Halt opcode seen in cycle K -> Halted=1, CoreReset=1 from K+1. CycleCount includes cycle K.
- Reset assertion forces reset values immediately, independent of Clock.

## Configuration
- RUN_CTRL_TIMEOUT_EN defined: in RUN, when CycleCount reaches MAX_CYCLES -> HALT with Timeout=1, HaltPC captured. Halt opcode in the same cycle -> HALT with Timeout=0 (opcode wins).
- Not defined: no watchdog logic; Timeout tied 0; RUN ends only by halt opcode, Abort or Reset.

## Structure
- Shared package nrisc_pkg: state enum (IDLE, LOAD, ARM, RUN, HALT), HALT_OPCODE=8'h00, ADDR_W/DATA_W defaults.
- One sub-module cycle_watchdog: saturating CycleCount counter with clear/enable and MAX_CYCLES compare (compare present only under RUN_CTRL_TIMEOUT_EN).

## Test plan
- Reset mid-LOAD after 3 bytes -> all outputs at reset values asynchronously; CoreReset=1, ProgLen=0.
- Load 4 bytes {8'h41,8'h52,8'h13,8'h00} with LoadValid held high and Last on byte 4 -> ImemWrite strobes at addrs 0..3 on four consecutive cycles, ProgLen=4, ARM one cycle, CoreReset low next.
- Drive CoreInstr nonzero for 7 RUN cycles, then 8'h00 with CorePC=8'h03 -> Halted=1, HaltPC=8'h03, CycleCount=8, CoreReset=1.
- Stream 256 bytes without LoadLast -> LoadReady drops after addr 8'hFF, ProgLen=256, no write to addr 0 a second time.
- Abort and Start both high in HALT -> IDLE, Halted=0; Start alone in HALT -> LOAD with CycleCount cleared.
- With RUN_CTRL_TIMEOUT_EN, MAX_CYCLES=10, no halt opcode -> HALT after 10 RUN cycles, Timeout=1; without the macro, RUN persists past 10 cycles.
